// File: rtl/pulse_swallow_ctrl.sv
// rtl/pulse_swallow_ctrl.sv - pulse-swallow sequencer for the dual-modulus prescaler.
// Holds mc high for the first S prescaler cycles of each P-cycle period and pulses div_out on the last one.
module pulse_swallow_ctrl #(
    parameter int P_WIDTH = 5,
    parameter int S_WIDTH = 3,
    parameter int P_MIN   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [P_WIDTH-1:0] Pi,
    input  logic [S_WIDTH-1:0] Si,
    input  logic               ps_valid,
    output logic               ps_ack,
    output logic               mc,
    output logic               div_out,
    output logic               busy,
    output logic               err_clamp,
    output logic               err_underrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SWALLOW = 2'd1,
        MAIN    = 2'd2
    } state_t;

    localparam logic [P_WIDTH-1:0] P_MIN_V = P_WIDTH'(P_MIN);

    state_t             state;
    logic [P_WIDTH-1:0] p_cnt;
    logic [P_WIDTH-1:0] p_reg;
    logic [P_WIDTH-1:0] s_reg;

    logic [P_WIDTH-1:0] si_ext;
    logic [P_WIDTH-1:0] p_new;
    logic [P_WIDTH-1:0] s_new;
    logic               clamp_new;
    logic [P_WIDTH-1:0] p_sel;
    logic [P_WIDTH-1:0] s_sel;
    logic [P_WIDTH-1:0] j_next;
    logic               at_end;

    always_comb begin
        si_ext    = P_WIDTH'(Si);
        p_new     = (Pi < P_MIN_V) ? P_MIN_V : Pi;
        s_new     = (si_ext > p_new) ? p_new : si_ext;
        clamp_new = (Pi < P_MIN_V) || (si_ext > p_new);
        // Without a fresh pair the previous period's values are reused.
        p_sel     = ps_valid ? p_new : p_reg;
        s_sel     = ps_valid ? s_new : s_reg;
        j_next    = p_cnt + 1'b1;
        at_end    = (p_cnt == p_reg - 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            p_cnt        <= '0;
            p_reg        <= P_MIN_V;
            s_reg        <= '0;
            ps_ack       <= 1'b0;
            mc           <= 1'b0;
            div_out      <= 1'b0;
            busy         <= 1'b0;
            err_clamp    <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            ps_ack <= 1'b0;
            if ((state == IDLE && !(en && ps_valid)) || (state != IDLE && at_end && !en)) begin
                state   <= IDLE;
                p_cnt   <= '0;
                mc      <= 1'b0;
                div_out <= 1'b0;
                busy    <= 1'b0;
            end else if (state == IDLE || at_end) begin
                // Period boundary: start a new period with the selected P/S pair.
                p_reg   <= p_sel;
                s_reg   <= s_sel;
                p_cnt   <= '0;
                mc      <= (s_sel != '0);
                div_out <= (p_sel == P_WIDTH'(1));
                busy    <= 1'b1;
                state   <= (s_sel != '0) ? SWALLOW : MAIN;
                if (ps_valid) begin
                    ps_ack <= 1'b1;
                    if (clamp_new) begin
                        err_clamp <= 1'b1;
                    end
                end else begin
                    err_underrun <= 1'b1;
                end
            end else begin
                p_cnt   <= j_next;
                mc      <= (j_next < s_reg);
                div_out <= (j_next == p_reg - 1'b1);
                state   <= (j_next < s_reg) ? SWALLOW : MAIN;
            end
        end
    end

endmodule

// File: tb/tb_pulse_swallow_ctrl.sv
// tb/tb_pulse_swallow_ctrl.sv - self-checking bench for pulse_swallow_ctrl.
module tb_pulse_swallow_ctrl;

    localparam int PW   = 5;
    localparam int SW   = 3;
    localparam int PMIN = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          ps_valid = 1'b0;
    logic [PW-1:0] Pi = '0;
    logic [SW-1:0] Si = '0;
    logic          ps_ack;
    logic          mc;
    logic          div_out;
    logic          busy;
    logic          err_clamp;
    logic          err_underrun;

    pulse_swallow_ctrl #(.P_WIDTH(PW), .S_WIDTH(SW), .P_MIN(PMIN)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .Pi           (Pi),
        .Si           (Si),
        .ps_valid     (ps_valid),
        .ps_ack       (ps_ack),
        .mc           (mc),
        .div_out      (div_out),
        .busy         (busy),
        .err_clamp    (err_clamp),
        .err_underrun (err_underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model: a queue holding the expected output of every remaining cycle of the current period.
    typedef struct packed {
        logic mc;
        logic div;
        logic ack;
    } cyc_t;

    cyc_t q[$];
    logic m_clamp = 1'b0;
    logic m_under = 1'b0;
    int   m_p = PMIN;
    int   m_s = 0;

    task automatic push_period(input int p, input int s, input logic ack);
        cyc_t c;
        for (int j = 0; j < p; j++) begin
            c.mc  = (j < s);
            c.div = (j == p - 1);
            c.ack = ack && (j == 0);
            q.push_back(c);
        end
    endtask

    task automatic model_latch(input int pi, input int si);
        int pe;
        int se;
        pe = (pi < PMIN) ? PMIN : pi;
        se = (si > pe) ? pe : si;
        if (pe != pi || se != si) m_clamp = 1'b1;
        m_p = pe;
        m_s = se;
        push_period(pe, se, 1'b1);
    endtask

    task automatic model_step(input logic r, input logic e, input logic v, input int pi, input int si);
        if (r) begin
            q.delete();
            m_p = PMIN;
            m_s = 0;
            m_clamp = 1'b0;
            m_under = 1'b0;
        end else if (q.size() == 0) begin
            if (e && v) model_latch(pi, si);
        end else begin
            void'(q.pop_front());
            if (q.size() == 0 && e) begin
                if (v) begin
                    model_latch(pi, si);
                end else begin
                    m_under = 1'b1;
                    push_period(m_p, m_s, 1'b0);
                end
            end
        end
    endtask

    function automatic logic [5:0] model_out();
        cyc_t c;
        if (q.size() == 0) return {4'b0000, m_clamp, m_under};
        c = q[0];
        return {c.mc, c.div, c.ack, 1'b1, m_clamp, m_under};
    endfunction

    function automatic logic [5:0] dut_out();
        return {mc, div_out, ps_ack, busy, err_clamp, err_underrun};
    endfunction

    task automatic compare(input string name, input logic [5:0] act, input logic [5:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d actual {mc,div,ack,busy,clamp,under}=%b required %b", name, cycle, act, req);
        end
    endtask

    // Apply one cycle of inputs, advance the model at the same edge, compare shortly after the edge.
    task automatic tick(input string name, input logic r, input logic e, input logic v, input int pi, input int si);
        rst = r;
        en = e;
        ps_valid = v;
        Pi = PW'(pi);
        Si = SW'(si);
        @(posedge clk);
        model_step(r, e, v, pi, si);
        #1;
        cycle++;
        compare(name, dut_out(), model_out());
    endtask

    typedef struct {
        logic       r;
        logic       e;
        logic       v;
        int         pi;
        int         si;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(input logic r, input logic e, input logic v, input int pi, input int si,
                                input logic [5:0] exp);
        vec_t t;
        t.r = r; t.e = e; t.v = v; t.pi = pi; t.si = si; t.exp = exp;
        return t;
    endfunction

    initial begin
        // Expected bits: {mc, div_out, ps_ack, busy, err_clamp, err_underrun} after the edge.
        tbl[0]  = mk(1, 0, 0, 0, 0, 6'b000000);
        tbl[1]  = mk(0, 1, 1, 5, 2, 6'b101100);
        tbl[2]  = mk(0, 1, 1, 5, 2, 6'b100100);
        tbl[3]  = mk(0, 1, 1, 5, 2, 6'b000100);
        tbl[4]  = mk(0, 1, 1, 5, 2, 6'b000100);
        tbl[5]  = mk(0, 1, 1, 5, 2, 6'b010100);
        tbl[6]  = mk(0, 1, 1, 4, 0, 6'b001100);
        tbl[7]  = mk(0, 1, 1, 4, 0, 6'b000100);
        tbl[8]  = mk(0, 1, 1, 4, 0, 6'b000100);
        tbl[9]  = mk(0, 1, 1, 4, 0, 6'b010100);
        tbl[10] = mk(0, 1, 1, 4, 4, 6'b101100);
        tbl[11] = mk(0, 1, 1, 4, 4, 6'b100100);
        tbl[12] = mk(0, 1, 1, 4, 4, 6'b100100);
        tbl[13] = mk(0, 1, 1, 4, 4, 6'b110100);
        tbl[14] = mk(0, 1, 1, 1, 0, 6'b001110);
        tbl[15] = mk(0, 1, 1, 1, 0, 6'b010110);
        tbl[16] = mk(0, 1, 1, 3, 6, 6'b101110);
        tbl[17] = mk(0, 1, 1, 3, 6, 6'b100110);
        tbl[18] = mk(0, 1, 1, 3, 6, 6'b110110);
        tbl[19] = mk(0, 1, 0, 5, 2, 6'b100111);
        tbl[20] = mk(0, 1, 0, 5, 2, 6'b100111);
        tbl[21] = mk(0, 1, 0, 5, 2, 6'b110111);
        tbl[22] = mk(0, 0, 1, 5, 2, 6'b000011);
        tbl[23] = mk(1, 0, 0, 0, 0, 6'b000000);

        for (int i = 0; i < 24; i++) begin
            tick("model_table", tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].pi, tbl[i].si);
            compare($sformatf("table_row_%0d", i), dut_out(), tbl[i].exp);
        end

        // Underrun mid-run: five cycles without ps_valid always span exactly one boundary of a 5-cycle period.
        tick("underrun_rst", 1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) tick("underrun_run", 0, 1, 1, 5, 2);
        for (int i = 0; i < 5; i++) tick("underrun_gap", 0, 1, 0, 5, 2);
        for (int i = 0; i < 10; i++) tick("underrun_resume", 0, 1, 1, 5, 2);
        compare("underrun_sticky", {5'b0, err_underrun}, 6'b000001);

        // en drops at p_cnt=1 of a 4-cycle period: the period still finishes with div_out.
        tick("en_drop_rst", 1, 0, 0, 0, 0);
        tick("en_drop_latch", 0, 1, 1, 4, 0);
        for (int i = 0; i < 8; i++) tick("en_drop_tail", 0, 0, 1, 4, 0);
        compare("en_drop_idle", {2'b0, busy, mc, ps_ack, div_out}, 6'b000000);

        // Reset while in SWALLOW, then restart as in the first scenario.
        tick("swallow_rst_pre", 1, 0, 0, 0, 0);
        tick("swallow_rst_latch", 0, 1, 1, 5, 2);
        tick("swallow_rst_run", 0, 1, 1, 5, 2);
        tick("swallow_rst_hit", 1, 1, 1, 5, 2);
        compare("swallow_rst_state", dut_out(), 6'b000000);
        for (int i = 0; i < 12; i++) tick("swallow_rst_restart", 0, 1, 1, 5, 2);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            tick("random",
                 ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 15) != 0),
                 ($urandom_range(0, 7) != 0),
                 int'($urandom_range(0, (1 << PW) - 1)),
                 int'($urandom_range(0, (1 << SW) - 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_swallow_ctrl.md
Name: pulse_swallow_ctrl

Overview:
Sequences the dual-modulus prescaler of the fractional-N divider using the per-period P/S values produced by the P/S split stage. Runs one output period at a time, clocked by the prescaler output. Drives modulus control high for the first S prescaler cycles and low for the remaining P−S cycles. Emits one divider output pulse per period and handshakes the next P/S pair at each period boundary, so the upstream sigma-delta advances exactly once per period.

Parameters:
P_WIDTH, 5, width of P (main counter) value
S_WIDTH, 3, width of S (swallow counter) value
P_MIN, 2, minimum legal P; smaller Pi is clamped up to this value

Ports:
clk  input  1  prescaler output clock; the only clock
rst  input  1  synchronous reset, active-high
en  input  1  run enable
Pi  input  P_WIDTH  next-period P value
Si  input  S_WIDTH  next-period S value
ps_valid  input  1  Pi/Si are valid for consumption
ps_ack  output  1  one-cycle pulse: Pi/Si pair was consumed
mc  output  1  modulus control: 1 = divide by N+1, 0 = divide by N
div_out  output  1  one-cycle pulse on the last cycle of each period
busy  output  1  controller is not IDLE
err_clamp  output  1  sticky: a P or S value was clamped
err_underrun  output  1  sticky: ps_valid was low at a running boundary

Behaviour:
- Reset is synchronous and active-high; clock is clk. While rst=1, on the next edge: state=IDLE, p_cnt=0, p_reg=P_MIN, s_reg=0, and all outputs 0. Reset applies in any state, including mid-period, and clears both sticky flags. Reset is the only way to clear the flags.
- States:
  - IDLE
  - SWALLOW (mc=1)
  - MAIN (mc=0)
- All outputs are registered. In the cycle where p_cnt=j:
  - mc = (j < s_eff)
  - div_out = (j == p_eff−1)
- Latch rule at a boundary with ps_valid=1:
  - p_eff = max(Pi, P_MIN)
  - s_eff = min(Si, p_eff)
  - err_clamp is set if either value was modified.
- Boundary definition:
  - In IDLE: en=1 and ps_valid=1. If en=1 and ps_valid=0, stay in IDLE with no ack and no flag.
  - While running: the cycle where p_cnt = p_eff−1.
- At a boundary with ps_valid=1: latch as above. ps_ack=1 in the next cycle, which is the p_cnt=0 cycle of the new period.
- At a running boundary with ps_valid=0: reuse p_reg/s_reg, set err_underrun, no ack.
- ps_valid outside a boundary is ignored: no ack, no latch.
- Period timing:
  - Periods are back-to-back with no gap cycles; period length is exactly p_eff cycles.
  - Latency from IDLE latch edge to first mc/div_out-bearing cycle is 1 cycle.
- Transitions:
  - From the latch: go to SWALLOW if s_eff>0, else MAIN.
  - In SWALLOW at p_cnt = s_eff−1: go to MAIN, unless s_eff = p_eff, in which case the period ends in SWALLOW.
  - At the period end: go to SWALLOW or MAIN per the newly latched values.
- en=0 while running: the current period completes, including div_out. At that boundary go to IDLE with no latch and no ack; mc=0 and busy=0 from the next cycle. en does not truncate a period.
- busy = (state != IDLE).

Test Plan:
- Reset; en=1, ps_valid=1, Pi=5, Si=2 held → ps_ack on the first cycle after the latch, then once every 5 cycles; mc repeats 1,1,0,0,0; div_out high on the 5th cycle of each period; busy=1.
- Si=0, Pi=4 → mc stays 0 and the state goes straight to MAIN. Si=4, Pi=4 → mc=1 for all 4 cycles and div_out on cycle 4; err_clamp stays 0.
- Pi=1, Si=0 → 2-cycle periods and err_clamp=1. Pi=3, Si=6 → mc=1,1,1 and err_clamp=1.
- Run Pi=5/Si=2, then drop ps_valid before one boundary → the next period repeats 1,1,0,0,0 with no ack, and err_underrun=1 and stays sticky after ps_valid returns.
- en=0 at p_cnt=1 → the remaining 3 cycles complete with div_out, then busy=0, mc=0, no further ps_ack.
- rst=1 during SWALLOW → the next cycle has mc=div_out=ps_ack=busy=0 and both flags 0; the restart behaves as in the first scenario.
